// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: pi_flag/pi_data strobes feed a byte FIFO drained onto tx.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits (11-bit frames).
module uart_tx_buf #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          pi_flag,
    input  logic [7:0]                    pi_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             tx_nxt;
    logic             pop;
    logic             bit_end;
    logic             wr_en;
    logic             fifo_empty;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    // Handshake: pi_flag is a per-edge write enable with no backpressure;
    // a write arriving while the FIFO is full is dropped and flagged on overflow.
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign wr_en      = pi_flag && !fifo_full;
    assign bit_end    = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));
    assign tx_busy    = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    tx_nxt      = shift_reg[0];
                    shift_nxt   = shift_reg >> 1;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = parity;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        tx_nxt      = shift_reg[0];
                        shift_nxt   = shift_reg >> 1;
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Pop at the end of the stop bit so queued frames run back to back.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            tx        <= tx_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            if (pop || state == IDLE || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            parity <= 1'b0;
        else if (pop)
            parity <= ^mem[rd_ptr];
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_ptr] <= pi_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= pi_flag && fifo_full;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: a line monitor decodes frames and checks them
// against an expected-byte queue filled when strobes are issued.
module tb_uart_tx_buf;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int UART_BPS   = 100_000;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CLKS   = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    logic exp_line [0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int FRAME_BITS = 10;
    logic exp_line [0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pi_flag;
    logic [7:0] pi_data;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic [4:0] fifo_cnt;
    logic       overflow;

    logic [7:0] exp_q [$];
    int         frame_start [$];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;

    uart_tx_buf #(
        .UART_BPS  (UART_BPS),
        .CLK_FREQ  (CLK_FREQ),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .pi_flag  (pi_flag),
        .pi_data  (pi_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .fifo_full(fifo_full),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow)
    );

    // Clock and cycle counter
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic check_contiguous(input string name, input int first, input int count);
        for (int i = first + 1; i < first + count; i++)
            check($sformatf("%s_gap%0d", name, i - first), 32'(frame_start[i] - frame_start[i-1]),
                  32'(FRAME_CLKS));
    endtask

    // Line monitor: samples mid-bit, pops the expected queue per completed frame
    initial begin : monitor
        logic       bits [0:10];
        logic [7:0] b;
        logic [7:0] e;
        logic       ab;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && tx == 1'b0) begin
                frame_start.push_back(cyc);
                ab = 1'b0;
                for (int s = 1; s <= 5 + BIT_CLKS * (FRAME_BITS - 1); s++) begin
                    @(negedge sys_clk);
                    if (!sys_rst_n) ab = 1'b1;
                    if (s >= 5 && (s - 5) % BIT_CLKS == 0) bits[(s - 5) / BIT_CLKS] = tx;
                end
                if (!ab) begin
                    for (int i = 0; i < 8; i++) b[i] = bits[i+1];
                    check("mon_start_bit", 32'(bits[0]), 32'd0);
                    check("mon_stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
                    check("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("mon_data", 32'(b), 32'(e));
`ifdef UART_TX_PARITY_EN
                        check("mon_parity", 32'(bits[9]), 32'(^e));
`endif
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int f0;
        int peak;
        int ovf;
        int low;
        sys_rst_n = 1'b0;
        pi_flag   = 1'b0;
        pi_data   = 8'h00;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single 0xA5 into an idle block: waveform and latency
        exp_q.push_back(8'hA5);
        pi_flag = 1'b1;
        pi_data = 8'hA5;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t1_tx_before_fall", 32'(tx), 32'd1);
        check("t1_cnt_queued", 32'(fifo_cnt), 32'd1);
        @(negedge sys_clk);
        check("t1_busy_at_fall", 32'(tx_busy), 32'd1);
        check("t1_cnt_popped", 32'(fifo_cnt), 32'd0);
        for (int s = 0; s < FRAME_CLKS; s++) begin
            if (s % BIT_CLKS == 0 || s % BIT_CLKS == BIT_CLKS - 1)
                check($sformatf("t1_bit%0d_clk%0d", s / BIT_CLKS, s % BIT_CLKS), 32'(tx),
                      32'(exp_line[s / BIT_CLKS]));
            if (s == FRAME_CLKS - 1) check("t1_busy_last", 32'(tx_busy), 32'd1);
            @(negedge sys_clk);
        end
        check("t1_busy_end", 32'(tx_busy), 32'd0);
        check("t1_tx_idle", 32'(tx), 32'd1);
        wait_drain("t1_drain", 500);

        // Burst of three on consecutive cycles
        f0   = frame_start.size();
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            pi_flag = 1'b1;
            pi_data = 8'(i);
            @(negedge sys_clk);
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
        end
        pi_flag = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
        end
        check("t2_peak_cnt", 32'(peak), 32'd2);
        wait_drain("t2_drain", 1000);
        check("t2_frames", 32'(frame_start.size() - f0), 32'd3);
        check_contiguous("t2", f0, 3);
        check("t2_cnt_end", 32'(fifo_cnt), 32'd0);

        // Overflow: 18 strobes, the 18th is dropped
        f0  = frame_start.size();
        ovf = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) exp_q.push_back(8'(8'h10 + i));
            pi_flag = 1'b1;
            pi_data = 8'(8'h10 + i);
            @(negedge sys_clk);
            if (overflow) ovf++;
            if (i == 16) begin
                check("t3_full", 32'(fifo_full), 32'd1);
                check("t3_cnt_full", 32'(fifo_cnt), 32'd16);
            end
        end
        pi_flag = 1'b0;
        repeat (5) begin
            @(negedge sys_clk);
            if (overflow) ovf++;
        end
        check("t3_ovf_pulses", 32'(ovf), 32'd1);
        wait_drain("t3_drain", 3000);
        check("t3_frames", 32'(frame_start.size() - f0), 32'd17);
        check("t3_full_end", 32'(fifo_full), 32'd0);

        // Reset at clock 45 of a 0x00 frame with one more byte queued
        f0 = frame_start.size();
        pi_flag = 1'b1;
        pi_data = 8'h00;
        repeat (2) @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (44) @(negedge sys_clk);
        check("t4_tx_before", 32'(tx), 32'd0);
        check("t4_cnt_before", 32'(fifo_cnt), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("t4_tx_async", 32'(tx), 32'd1);
        check("t4_cnt_async", 32'(fifo_cnt), 32'd0);
        check("t4_busy_async", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        low = 0;
        repeat (300) begin
            @(negedge sys_clk);
            if (tx == 1'b0) low++;
        end
        check("t4_line_quiet", 32'(low), 32'd0);
        check("t4_frames", 32'(frame_start.size() - f0), 32'd1);

        // Write and pop on the same edge at the end of STOP with one byte queued
        f0 = frame_start.size();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5A);
        pi_flag = 1'b1;
        pi_data = 8'h3C;
        @(negedge sys_clk);
        pi_data = 8'hC3;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (FRAME_CLKS - 1) @(negedge sys_clk);
        check("t5_cnt_before", 32'(fifo_cnt), 32'd1);
        check("t5_stop_bit", 32'(tx), 32'd1);
        pi_flag = 1'b1;
        pi_data = 8'h5A;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        check("t5_cnt_same", 32'(fifo_cnt), 32'd1);
        check("t5_next_start", 32'(tx), 32'd0);
        check("t5_busy", 32'(tx_busy), 32'd1);
        wait_drain("t5_drain", 1000);
        check("t5_frames", 32'(frame_start.size() - f0), 32'd3);
        check_contiguous("t5", f0, 3);

`ifdef UART_TX_PARITY_EN
        // Parity bits for 0x07 then 0x03
        f0 = frame_start.size();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        pi_flag = 1'b1;
        pi_data = 8'h07;
        @(negedge sys_clk);
        pi_data = 8'h03;
        @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (95) @(negedge sys_clk);
        check("t6_parity_07", 32'(tx), 32'd1);
        repeat (110) @(negedge sys_clk);
        check("t6_parity_03", 32'(tx), 32'd0);
        wait_drain("t6_drain", 1000);
        check("t6_frames", 32'(frame_start.size() - f0), 32'd2);
        check_contiguous("t6", f0, 2);
`endif

        repeat (5) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
